// File: rtl/rf_arb_pkg.sv
// ----------------------------------------------------------------------------
// rf_arb_pkg
// Shared definitions for the register-file writeback arbiter.
//   rf_state_e : FSM states (CLEAR runs the power-up zeroing sweep, RUN
//                arbitrates writeback traffic).
//   NUM_REGS   : number of architectural registers.
//   FIRST_REG  : first address written by the clear sweep (x0 is hardwired).
//   LAST_REG   : last address written by the clear sweep.
// ----------------------------------------------------------------------------
package rf_arb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int         NUM_REGS  = 32;
    localparam logic [4:0] FIRST_REG = 5'd1;
    localparam logic [4:0] LAST_REG  = 5'd31;

endpackage

// File: rtl/rf_rr_arb2.sv
// ----------------------------------------------------------------------------
// rf_rr_arb2
// Two-requester round-robin grant logic, purely combinational.
//   valid0, valid1 : request lines
//   ptr            : priority pointer (0 -> requester 0 wins ties)
//   gnt0, gnt1     : one-hot (or zero) grant; an idle requester never wins
// ----------------------------------------------------------------------------
module rf_rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = valid0 & (~valid1 | ~ptr);
    assign gnt1 = valid1 & (~valid0 |  ptr);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges two writeback requesters onto the single register-file write port
// (WE3/A3/WD3) with round-robin arbitration, and optionally zeroes registers
// 1..31 after reset.
//
// Build option: define RF_CLEAR_EN to compile in the post-reset clear sweep
// (CLEAR state, 5-bit address counter, busy flag). Without it the block is
// always in RUN and busy is tied low.
//
// Ports
//   clk, rst_n               : rising-edge clock, async active-low reset
//   req0_valid/addr/data     : writeback requester 0; req0_ready handshake
//   req1_valid/addr/data     : writeback requester 1; req1_ready handshake
//   rf_we, rf_addr, rf_wd    : registered register-file write port
//   busy                     : clear sweep in progress
//   grant_id                 : requester that produced the current rf beat
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_data,
    output logic                     req0_ready,

    input  logic                     req1_valid,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_data,
    output logic                     req1_ready,

    output logic                     rf_we,
    output logic [ADDRESS_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0]    rf_wd,

    output logic                     busy,
    output logic                     grant_id
);

    logic                     rf_we_q,    rf_we_d;
    logic [ADDRESS_WIDTH-1:0] rf_addr_q,  rf_addr_d;
    logic [DATA_WIDTH-1:0]    rf_wd_q,    rf_wd_d;
    logic                     grant_id_q, grant_id_d;
    logic                     ptr_q,      ptr_d;

    logic                     gnt0, gnt1;
    logic                     run_en;
    logic                     xfer;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

`ifdef RF_CLEAR_EN
    rf_state_e  state_q,   state_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;

    assign run_en = (state_q == RUN);
    assign busy   = (state_q == CLEAR);
`else
    assign run_en = 1'b1;
    assign busy   = 1'b0;
`endif

    rf_rr_arb2 u_arb (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ptr    (ptr_q),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    // Gating with rst_n keeps ready low throughout reset even in the build
    // where the FSM has no CLEAR state to hold it off.
    assign req0_ready = rst_n & run_en & gnt0;
    assign req1_ready = rst_n & run_en & gnt1;

    assign xfer     = req0_ready | req1_ready;
    assign sel_addr = req1_ready ? req1_addr : req0_addr;
    assign sel_data = req1_ready ? req1_data : req0_data;

    always_comb begin
        // RUN behaviour: one registered beat per accepted transfer; writes to
        // address 0 are consumed but never reach the register file.
        rf_we_d    = xfer && (sel_addr != '0);
        rf_addr_d  = xfer ? sel_addr   : rf_addr_q;
        rf_wd_d    = xfer ? sel_data   : rf_wd_q;
        grant_id_d = xfer ? req1_ready : grant_id_q;
        // Pointer flips to the requester that did not just win.
        ptr_d      = xfer ? req0_ready : ptr_q;

`ifdef RF_CLEAR_EN
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            rf_we_d   = 1'b1;
            rf_addr_d = ADDRESS_WIDTH'(clr_cnt_q);
            rf_wd_d   = '0;
            // The counter stops at LAST_REG rather than wrapping to 0.
            if (clr_cnt_q == LAST_REG) begin
                state_d = RUN;
            end else begin
                clr_cnt_d = clr_cnt_q + 5'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wd_q    <= '0;
            grant_id_q <= 1'b0;
            ptr_q      <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wd_q    <= rf_wd_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
        end
    end

`ifdef RF_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= FIRST_REG;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end
`endif

    assign rf_we    = rf_we_q;
    assign rf_addr  = rf_addr_q;
    assign rf_wd    = rf_wd_q;
    assign grant_id = grant_id_q;

endmodule
